// File: rtl/pipelined_datapath.sv
// Five-stage (F/D/E/M/W) RV32I-style datapath: PC, pipeline registers,
// register file, immediate extension, ALU, forwarding and hazard unit.
// Control is decoded outside from InstrD and carried down the pipe here.
module pipelined_datapath #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP      = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [31:0]     InstrD,
  input  logic            RegWriteD,
  input  logic [1:0]      ResultSrcD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            BranchD,
  input  logic [2:0]      ALUControlD,
  input  logic            ALUSrcD,
  input  logic [1:0]      ImmSrcD,
  input  logic [XLEN-1:0] ReadDataM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic            MemWriteM,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic            FlushE
);

  localparam int unsigned ILEN = 32;
  localparam int unsigned RLEN = 5;
  localparam int unsigned NREG = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {FWD_RF, FWD_W, FWD_M} fwd_e;

  // F / D
  logic [XLEN-1:0] pcplus4_f;
  logic [XLEN-1:0] pc_d, pcplus4_d;
  logic [RLEN-1:0] rs1_d, rs2_d, rd_d;
  logic [XLEN-1:0] rd1_d, rd2_d, immext_d;
  logic [ILEN-1:0] imm_d;

  // E
  logic            regwrite_e, memwrite_e, jump_e, branch_e, alusrc_e;
  logic [1:0]      resultsrc_e;
  logic [2:0]      alucontrol_e;
  logic [XLEN-1:0] rd1_e, rd2_e, pc_e, immext_e, pcplus4_e;
  logic [RLEN-1:0] rs1_e, rs2_e, rd_e;
  fwd_e            fwd_a, fwd_b;
  logic [XLEN-1:0] srca_e, srcb_e, writedata_e, aluresult_e, pctarget_e;
  logic            zero_e, pcsrc_e, lwstall;

  // M
  logic            regwrite_m;
  logic [1:0]      resultsrc_m;
  logic [RLEN-1:0] rd_m;
  logic [XLEN-1:0] pcplus4_m;

  // W
  logic            regwrite_w;
  logic [1:0]      resultsrc_w;
  logic [RLEN-1:0] rd_w;
  logic [XLEN-1:0] aluresult_w, readdata_w, pcplus4_w, result_w;

  logic [XLEN-1:0] rf [NREG];

  assign pcplus4_f = PCF + XLEN'(4);

  // Fetch PC: a redirect from E overrides a load-use stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          PCF <= RESET_PC;
    else if (pcsrc_e)   PCF <= pctarget_e;
    else if (!StallF)   PCF <= pcplus4_f;
  end

  // F/D register: flush beats stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset || FlushD) begin
      InstrD    <= NOP;
      pc_d      <= '0;
      pcplus4_d <= '0;
    end else if (!StallD) begin
      InstrD    <= InstrF;
      pc_d      <= PCF;
      pcplus4_d <= pcplus4_f;
    end
  end

  assign rs1_d = InstrD[19:15];
  assign rs2_d = InstrD[24:20];
  assign rd_d  = InstrD[11:7];

  // Register file write from W; x0 is never written
  always_ff @(posedge clk) begin
    if (regwrite_w && (rd_w != '0)) rf[rd_w] <= result_w;
  end

  // Register file read with x0 forced to zero and write-through from W
  always_comb begin
    rd1_d = rf[rs1_d];
    rd2_d = rf[rs2_d];
    if (rs1_d == '0)                            rd1_d = '0;
    else if (regwrite_w && (rd_w == rs1_d))     rd1_d = result_w;
    if (rs2_d == '0)                            rd2_d = '0;
    else if (regwrite_w && (rd_w == rs2_d))     rd2_d = result_w;
  end

  // Immediate extension for I/S/B/J formats
  always_comb begin
    imm_d = '0;
    case (ImmSrcD)
      2'b00:   imm_d = {{20{InstrD[31]}}, InstrD[31:20]};
      2'b01:   imm_d = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      2'b10:   imm_d = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      default: imm_d = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
    endcase
    immext_d = XLEN'($signed(imm_d));
  end

  // D/E register: a flush (branch or load-use bubble) loads zero controls
  always_ff @(posedge clk or posedge reset) begin
    if (reset || FlushE) begin
      regwrite_e   <= 1'b0;
      resultsrc_e  <= 2'b00;
      memwrite_e   <= 1'b0;
      jump_e       <= 1'b0;
      branch_e     <= 1'b0;
      alucontrol_e <= 3'b000;
      alusrc_e     <= 1'b0;
      rd1_e        <= '0;
      rd2_e        <= '0;
      pc_e         <= '0;
      immext_e     <= '0;
      pcplus4_e    <= '0;
      rs1_e        <= '0;
      rs2_e        <= '0;
      rd_e         <= '0;
    end else begin
      regwrite_e   <= RegWriteD;
      resultsrc_e  <= ResultSrcD;
      memwrite_e   <= MemWriteD;
      jump_e       <= JumpD;
      branch_e     <= BranchD;
      alucontrol_e <= ALUControlD;
      alusrc_e     <= ALUSrcD;
      rd1_e        <= rd1_d;
      rd2_e        <= rd2_d;
      pc_e         <= pc_d;
      immext_e     <= immext_d;
      pcplus4_e    <= pcplus4_d;
      rs1_e        <= rs1_d;
      rs2_e        <= rs2_d;
      rd_e         <= rd_d;
    end
  end

  // Forwarding select: M is newer than W so it wins
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (regwrite_m && (rd_m == rs1_e) && (rs1_e != '0))      fwd_a = FWD_M;
    else if (regwrite_w && (rd_w == rs1_e) && (rs1_e != '0)) fwd_a = FWD_W;
    if (regwrite_m && (rd_m == rs2_e) && (rs2_e != '0))      fwd_b = FWD_M;
    else if (regwrite_w && (rd_w == rs2_e) && (rs2_e != '0)) fwd_b = FWD_W;
  end

  // Operand muxes after forwarding
  always_comb begin
    srca_e      = rd1_e;
    writedata_e = rd2_e;
    case (fwd_a)
      FWD_M:   srca_e = ALUResultM;
      FWD_W:   srca_e = result_w;
      default: srca_e = rd1_e;
    endcase
    case (fwd_b)
      FWD_M:   writedata_e = ALUResultM;
      FWD_W:   writedata_e = result_w;
      default: writedata_e = rd2_e;
    endcase
    srcb_e = alusrc_e ? immext_e : writedata_e;
  end

  // ALU
  always_comb begin
    aluresult_e = '0;
    case (alucontrol_e)
      ALU_ADD: aluresult_e = srca_e + srcb_e;
      ALU_SUB: aluresult_e = srca_e - srcb_e;
      ALU_AND: aluresult_e = srca_e & srcb_e;
      ALU_OR:  aluresult_e = srca_e | srcb_e;
      ALU_SLT: aluresult_e = XLEN'($signed(srca_e) < $signed(srcb_e));
      default: aluresult_e = '0;
    endcase
  end

  assign zero_e     = (aluresult_e == '0);
  assign pctarget_e = pc_e + immext_e;
  assign pcsrc_e    = (branch_e & zero_e) | jump_e;

  // Hazard unit: one bubble per load-use, squash F and D on redirect
  assign lwstall = (resultsrc_e == RES_MEM) && (rd_e != '0) &&
                   ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign StallF  = lwstall;
  assign StallD  = lwstall;
  assign FlushE  = lwstall | pcsrc_e;
  assign FlushD  = pcsrc_e;

  // E/M register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regwrite_m  <= 1'b0;
      resultsrc_m <= 2'b00;
      MemWriteM   <= 1'b0;
      ALUResultM  <= '0;
      WriteDataM  <= '0;
      rd_m        <= '0;
      pcplus4_m   <= '0;
    end else begin
      regwrite_m  <= regwrite_e;
      resultsrc_m <= resultsrc_e;
      MemWriteM   <= memwrite_e;
      ALUResultM  <= aluresult_e;
      WriteDataM  <= writedata_e;
      rd_m        <= rd_e;
      pcplus4_m   <= pcplus4_e;
    end
  end

  // M/W register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regwrite_w  <= 1'b0;
      resultsrc_w <= 2'b00;
      aluresult_w <= '0;
      readdata_w  <= '0;
      rd_w        <= '0;
      pcplus4_w   <= '0;
    end else begin
      regwrite_w  <= regwrite_m;
      resultsrc_w <= resultsrc_m;
      aluresult_w <= ALUResultM;
      readdata_w  <= ReadDataM;
      rd_w        <= rd_m;
      pcplus4_w   <= pcplus4_m;
    end
  end

  // Writeback result select; 11 falls back to the ALU result
  always_comb begin
    case (resultsrc_w)
      RES_MEM: result_w = readdata_w;
      RES_PC4: result_w = pcplus4_w;
      default: result_w = aluresult_w;
    endcase
  end

endmodule

// File: tb/tb_pipelined_datapath.sv
// Bench for pipelined_datapath: behavioural instruction/data memories, a small
// controller, store scoreboard and hazard-signal checks.
module tb_pipelined_datapath;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOPW = 32'h00000013;

  logic            clk, reset;
  logic [31:0]     InstrF, InstrD;
  logic [XLEN-1:0] PCF, ReadDataM, ALUResultM, WriteDataM;
  logic            RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, MemWriteM;
  logic [1:0]      ResultSrcD, ImmSrcD;
  logic [2:0]      ALUControlD;
  logic            StallF, StallD, FlushD, FlushE;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];

  typedef struct { string name; logic [31:0] addr; logic [31:0] data; } st_t;
  st_t sbq[$];

  typedef struct {
    string      name;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [11:0] a;
    logic [11:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [9];

  int checks, failures;
  int n_stall, n_flushd, n_flushe, n_stall_bad;

  pipelined_datapath #(.XLEN(XLEN), .RESET_PC('0), .NOP(NOPW)) dut (
    .clk(clk), .reset(reset), .InstrF(InstrF), .PCF(PCF), .InstrD(InstrD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .JumpD(JumpD), .BranchD(BranchD), .ALUControlD(ALUControlD),
    .ALUSrcD(ALUSrcD), .ImmSrcD(ImmSrcD), .ReadDataM(ReadDataM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .MemWriteM(MemWriteM),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb InstrF    = imem[PCF[9:2]];
  always_comb ReadDataM = dmem[ALUResultM[9:2]];

  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Controller stand-in; branches drive ResultSrc=01 (a don't-care for beq)
  always_comb begin
    RegWriteD = 1'b0; ResultSrcD = 2'b00; MemWriteD = 1'b0; JumpD = 1'b0;
    BranchD = 1'b0; ALUControlD = 3'b000; ALUSrcD = 1'b0; ImmSrcD = 2'b00;
    case (InstrD[6:0])
      7'b0000011: begin RegWriteD = 1'b1; ResultSrcD = 2'b01; ALUSrcD = 1'b1; end
      7'b0100011: begin MemWriteD = 1'b1; ALUSrcD = 1'b1; ImmSrcD = 2'b01; end
      7'b0110011: begin RegWriteD = 1'b1; ALUControlD = alu_dec(InstrD[14:12], InstrD[30]); end
      7'b0010011: begin RegWriteD = 1'b1; ALUSrcD = 1'b1; ALUControlD = alu_dec(InstrD[14:12], 1'b0); end
      7'b1100011: begin BranchD = 1'b1; ImmSrcD = 2'b10; ALUControlD = 3'b001; ResultSrcD = 2'b01; end
      7'b1101111: begin JumpD = 1'b1; RegWriteD = 1'b1; ResultSrcD = 2'b10; ImmSrcD = 2'b11; end
      default: ;
    endcase
  end

  function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_store(input string name, input logic [31:0] addr, input logic [31:0] data);
    st_t e;
    e.name = name; e.addr = addr; e.data = data;
    sbq.push_back(e);
  endtask

  // One cycle: sample on the falling edge, score stores, tally hazard signals
  task automatic step();
    st_t e;
    @(negedge clk);
    if (!reset) begin
      if (StallF) n_stall++;
      if (FlushD) n_flushd++;
      if (FlushE) n_flushe++;
      if ((StallF != StallD) || (StallF && !FlushE)) n_stall_bad++;
      if (MemWriteM) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_store: addr 0x%08h data 0x%08h with none pending", ALUResultM, WriteDataM);
        end else begin
          e = sbq.pop_front();
          chk({e.name, "_addr"}, ALUResultM, e.addr);
          chk({e.name, "_data"}, WriteDataM, e.data);
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic begin_prog();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 256; i++) imem[i] = NOPW;
    sbq.delete();
    n_stall = 0; n_flushd = 0; n_flushe = 0; n_stall_bad = 0;
  endtask

  task automatic release_prog();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic end_prog(input string name);
    chk({name, "_pending_stores"}, 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  task automatic hazard_counts(input string name, input int stall, input int fd, input int fe);
    chk({name, "_stall_cycles"}, 32'(n_stall), 32'(stall));
    chk({name, "_flushd_cycles"}, 32'(n_flushd), 32'(fd));
    chk({name, "_flushe_cycles"}, 32'(n_flushe), 32'(fe));
    chk({name, "_stall_consistency"}, 32'(n_stall_bad), 32'd0);
  endtask

  // Run n cycles; at the first redirect check PCF then and on the next cycle
  task automatic run_flush_watch(input string name, input int n, input logic [31:0] pc_flush,
                                 input logic [31:0] pc_next, input logic stall_at_flush);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (FlushD && (seen == 0)) begin
        seen = 1;
        chk({name, "_pc_at_flush"}, PCF, pc_flush);
        chk({name, "_flushe_at_flush"}, 32'(FlushE), 32'd1);
        chk({name, "_stall_at_flush"}, 32'(StallF), 32'(stall_at_flush));
        step();
        chk({name, "_pc_after_flush"}, PCF, pc_next);
      end
    end
    chk({name, "_flush_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    int seen;
    checks = 0; failures = 0;
    n_stall = 0; n_flushd = 0; n_flushe = 0; n_stall_bad = 0;
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      imem[i] = NOPW;
      dmem[i] = '0;
    end
    dmem[0] = 32'd7;

    // Asynchronous reset before any clock edge
    #1 reset = 1'b1;
    #2;
    chk("rst_pcf", PCF, 32'd0);
    chk("rst_instrd", InstrD, NOPW);
    chk("rst_memwritem", 32'(MemWriteM), 32'd0);
    chk("rst_aluresultm", ALUResultM, 32'd0);
    chk("rst_hazard", 32'({StallF, StallD, FlushD, FlushE}), 32'd0);

    // ALU table: addi x1; addi x2; op x3,x1,x2; sw x3 -- forwarding from M and W
    vt[0] = '{"add_pos",    7'h00, 3'b000, 12'd5,   12'd7,   32'd12};
    vt[1] = '{"add_neg",    7'h00, 3'b000, 12'hFFD, 12'd10,  32'd7};
    vt[2] = '{"sub_neg",    7'h20, 3'b000, 12'd5,   12'd7,   32'hFFFFFFFE};
    vt[3] = '{"sub_zero",   7'h20, 3'b000, 12'd100, 12'd100, 32'd0};
    vt[4] = '{"and",        7'h00, 3'b111, 12'h0F0, 12'h0FF, 32'h000000F0};
    vt[5] = '{"or",         7'h00, 3'b110, 12'h0F0, 12'h00F, 32'h000000FF};
    vt[6] = '{"slt_true",   7'h00, 3'b010, 12'hFFF, 12'd1,   32'd1};
    vt[7] = '{"slt_false",  7'h00, 3'b010, 12'd7,   12'd3,   32'd0};
    vt[8] = '{"and_negone", 7'h00, 3'b111, 12'hFFF, 12'h555, 32'h00000555};
    begin_prog();
    for (int i = 0; i < 9; i++) begin
      imem[4*i]   = enc_i(5'd1, 5'd0, vt[i].a);
      imem[4*i+1] = enc_i(5'd2, 5'd0, vt[i].b);
      imem[4*i+2] = enc_r(vt[i].f7, vt[i].f3, 5'd3, 5'd1, 5'd2);
      imem[4*i+3] = enc_sw(5'd3, 5'd0, 12'h300 + 12'(4*i));
      expect_store(vt[i].name, 32'h300 + 32'(4*i), vt[i].exp);
    end
    release_prog();
    run(44);
    hazard_counts("alu_table", 0, 0, 0);
    end_prog("alu_table");

    // Back-to-back dependency chain
    begin_prog();
    imem[0] = enc_i(5'd1, 5'd0, 12'd5);
    imem[1] = enc_r(7'h00, 3'b000, 5'd2, 5'd1, 5'd1);
    imem[2] = enc_r(7'h00, 3'b000, 5'd3, 5'd2, 5'd1);
    imem[3] = enc_sw(5'd2, 5'd0, 12'h100);
    imem[4] = enc_sw(5'd3, 5'd0, 12'h104);
    expect_store("fwd_x2", 32'h100, 32'd10);
    expect_store("fwd_x3", 32'h104, 32'd15);
    release_prog();
    run(14);
    hazard_counts("fwd", 0, 0, 0);
    end_prog("fwd");

    // Load-use: exactly one bubble
    begin_prog();
    imem[0] = enc_lw(5'd4, 5'd0, 12'd0);
    imem[1] = enc_r(7'h00, 3'b000, 5'd5, 5'd4, 5'd4);
    imem[2] = enc_sw(5'd5, 5'd0, 12'h108);
    expect_store("lduse_x5", 32'h108, 32'd14);
    release_prog();
    run(14);
    hazard_counts("lduse", 1, 0, 1);
    end_prog("lduse");

    // Taken beq at PC 8 to 20; instructions at 12 and 16 squashed
    begin_prog();
    imem[0] = enc_i(5'd6, 5'd0, 12'd1);
    imem[2] = enc_beq(5'd0, 5'd0, 13'd12);
    imem[3] = enc_i(5'd6, 5'd0, 12'd99);
    imem[4] = enc_i(5'd6, 5'd0, 12'd77);
    imem[5] = enc_sw(5'd6, 5'd0, 12'h10C);
    expect_store("beq_x6", 32'h10C, 32'd1);
    release_prog();
    run_flush_watch("beq", 14, 32'd16, 32'd20, 1'b0);
    hazard_counts("beq", 0, 1, 1);
    end_prog("beq");

    // jal x1,+8 at PC 4; write to x0 must not stick
    begin_prog();
    imem[0] = enc_i(5'd7, 5'd0, 12'd3);
    imem[1] = enc_jal(5'd1, 21'd8);
    imem[2] = enc_i(5'd7, 5'd0, 12'd55);
    imem[3] = enc_i(5'd0, 5'd0, 12'd9);
    imem[4] = enc_sw(5'd1, 5'd0, 12'h110);
    imem[5] = enc_sw(5'd0, 5'd0, 12'h114);
    imem[6] = enc_sw(5'd7, 5'd0, 12'h118);
    expect_store("jal_x1", 32'h110, 32'd8);
    expect_store("jal_x0", 32'h114, 32'd0);
    expect_store("jal_x7", 32'h118, 32'd3);
    release_prog();
    run_flush_watch("jal", 16, 32'd12, 32'd12, 1'b0);
    hazard_counts("jal", 0, 1, 1);
    end_prog("jal");

    // Load-use condition in D coincident with a taken branch in E
    begin_prog();
    imem[0] = enc_i(5'd9, 5'd0, 12'd4);
    imem[2] = enc_beq(5'd0, 5'd0, 13'd12);
    imem[3] = enc_r(7'h00, 3'b000, 5'd9, 5'd12, 5'd12);
    imem[4] = enc_i(5'd9, 5'd0, 12'd66);
    imem[5] = enc_sw(5'd9, 5'd0, 12'h11C);
    expect_store("coinc_x9", 32'h11C, 32'd4);
    release_prog();
    run_flush_watch("coinc", 14, 32'd16, 32'd20, 1'b1);
    hazard_counts("coinc", 1, 1, 1);
    end_prog("coinc");

    // Reset pulse while a store sits in M
    begin_prog();
    imem[0] = enc_i(5'd1, 5'd0, 12'd3);
    imem[1] = enc_sw(5'd1, 5'd0, 12'h200);
    expect_store("rst_first", 32'h200, 32'd3);
    release_prog();
    seen = 0;
    for (int i = 0; (i < 20) && (seen == 0); i++) begin
      step();
      if (MemWriteM) seen = 1;
    end
    chk("midrst_store_reached", 32'(seen), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_pcf", PCF, 32'd0);
    chk("midrst_memwritem", 32'(MemWriteM), 32'd0);
    chk("midrst_instrd", InstrD, NOPW);
    expect_store("rst_again", 32'h200, 32'd3);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_pcf0", PCF, 32'd0);
    chk("rel_instrd", InstrD, NOPW);
    step();
    chk("rel_pcf4", PCF, 32'd4);
    chk("rel_instrd_fetch", InstrD, enc_i(5'd1, 5'd0, 12'd3));
    step();
    chk("rel_pcf8", PCF, 32'd8);
    run(8);
    end_prog("reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_datapath.md
Name: pipelined_datapath

Overview:
- Parametrised five-stage (F/D/E/M/W) successor to the single-cycle RV32I datapath.
- Holds PC, the F/D, D/E, E/M and M/W pipeline registers, the register file, immediate extension, ALU, forwarding and the hazard unit.
- The controller decodes InstrD combinationally and drives D-stage control inputs; this block carries those controls down the pipe.
- Instruction and data memories stay outside the block.

Parameters:
- XLEN, 32, datapath and register width; instruction width is fixed at 32.
- RESET_PC, 0, PC value loaded on reset.
- NOP, 32'h00000013, instruction word (addi x0,x0,0) inserted on flush/reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- InstrF  in  32  instruction word at PCF
- PCF  out  XLEN  fetch address
- InstrD  out  32  decode-stage instruction, to controller
- RegWriteD  in  1  write rd
- ResultSrcD  in  2  00 ALU, 01 memory, 10 PC+4
- MemWriteD  in  1  store
- JumpD  in  1  jal
- BranchD  in  1  beq
- ALUControlD  in  3  ALU operation, same encoding as the existing ALU
- ALUSrcD  in  1  0 rs2, 1 immediate
- ImmSrcD  in  2  I/S/B/J select, same encoding as the existing extender
- ReadDataM  in  XLEN  data-memory read data
- ALUResultM  out  XLEN  data address
- WriteDataM  out  XLEN  store data
- MemWriteM  out  1  data-memory write enable
- StallF, StallD, FlushD, FlushE  out  1 each  hazard status, for debug and the bench

Behaviour:
- Reset (asynchronous, effective immediately):
  - PCF = RESET_PC.
  - InstrD = NOP.
  - All pipeline control bits are 0 (RegWrite, MemWrite, Jump, Branch, ResultSrc).
  - All pipeline data registers are 0.
  - MemWriteM = 0.
  - Register file contents are not reset.
  - Reset mid-operation discards every in-flight instruction.
- Stage F:
  - PCPlus4F = PCF+4.
  - PCF loads PCTargetE when PCSrcE=1, else PCPlus4F.
  - Holds when StallF=1.
  - PCSrcE has priority over StallF.
- Stage D:
  - Register file reads rs1=InstrD[19:15], rs2=InstrD[24:20].
  - Register file is 32 x XLEN; x0 always reads 0; writes to x0 are ignored.
  - Write occurs at the rising edge from the W stage.
  - Write-through: a D read of the register W is writing that cycle returns the new value.
- Stage E:
  - SrcAE = forwarded rs1; SrcBE = ALUSrcE ? ImmExtE : forwarded rs2.
  - PCTargetE = PCE + ImmExtE, with XLEN wrap-around.
  - PCSrcE = (BranchE & ZeroE) | JumpE.
- Stage M: outputs ALUResultM, WriteDataM (forwarded rs2) and MemWriteM.
- Stage W:
  - ResultW = mux(ALUResultW, ReadDataW, PCPlus4W) by ResultSrcW; 11 is treated as 00.
  - Written to RdW when RegWriteW=1.
- Forwarding (ForwardAE, same rule for ForwardBE with Rs2E):
  - Select M when RegWriteM & RdM==Rs1E & Rs1E!=0.
  - Else select W when RegWriteW & RdW==Rs1E & Rs1E!=0.
  - Else use the register-file value.
  - M has priority over W.
- Load-use stall: lwStall = (ResultSrcE==01) & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
  - StallF = StallD = lwStall.
  - FlushE = lwStall | PCSrcE.
  - FlushD = PCSrcE.
  - Result is exactly one bubble per load-use.
- Flush and stall priority:
  - Flush loads NOP/zero controls into the target register.
  - Stall holds the register.
  - When flush and stall hit the same register, flush wins.
- Branch/jump penalty: 2 cycles; the instructions in F and D are squashed.
- Latency: an instruction fetched at cycle n writes back at the edge ending cycle n+4.
- Throughput: one instruction per cycle absent hazards.

Test Plan:
- Reset pulse mid-run with RESET_PC=0 -> PCF=0 and MemWriteM=0 immediately; InstrD=NOP after release; PCF=0,4,8 on successive cycles.
- addi x1,x0,5; add x2,x1,x1; add x3,x2,x1 back-to-back -> M and W forwarding used, no stall; x2=10, x3=15.
- lw x4,0(x0) with mem[0]=7, then add x5,x4,x4 -> StallF/StallD high for exactly 1 cycle, FlushE=1 that cycle; x5=14.
- beq x0,x0,+12 at PC 8 -> PCSrcE=1, FlushD=FlushE=1 for 1 cycle; next PCF=20; squashed instructions at 12 and 16 never write.
- jal x1,+8 at PC 4 -> x1=8, PCF=12, 2-cycle penalty; a write to x0 leaves x0 reading 0.
- Load-use hazard in D coincident with a taken branch in E -> PCF=PCTargetE; both D and E flushed; the load-use bubble is not inserted twice.
